r0_op_issuer: RTL and testbench

R0_OP_ISSUER -- requirements
Module: r0_op_issuer

---
 rtl/r0_op_issuer.sv | 120 ++++++++++++
 tb/tb_r0_op_issuer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/r0_op_issuer.sv
// Issues one arithmetic op to the shared r0 multiplexer, waits for a fresh ready
// (stale ready from the previous op is filtered) and writes the result to r0/r1.
module r0_op_issuer #(
  parameter int unsigned TIMEOUT_CYCLES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] opcode,
  input  logic [7:0] operand_a,
  input  logic [7:0] operand_b,
  output logic       mux_en,
  output logic [1:0] mux_state,
  output logic [7:0] mux_value1,
  output logic [7:0] mux_value2,
  input  logic       mux_ready,
  input  logic [7:0] mux_out1,
  input  logic [7:0] mux_out2,
  output logic [7:0] r0,
  output logic [7:0] r1,
  output logic       busy,
  output logic       done,
  output logic       reject,
  output logic       err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB} state_t;

  localparam logic [1:0] OP_MUL   = 2'd2;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     r_state;
  state_t     w_next;
  logic       r_armed;
  logic [7:0] r_cnt;
  logic       w_capture;
  logic       w_timeout;

  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    w_timeout = 1'b0;
    mux_en    = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        mux_en = 1'b1;
        w_next = S_WAIT;
      end
      S_WAIT: begin
        mux_en = 1'b1;
        // A ready is only trusted once the mux has been seen low for this op.
        if (r_armed && mux_ready) begin
          w_capture = 1'b1;
          w_next    = S_WB;
        end else if (r_cnt == CNT_LAST) begin
          w_timeout = 1'b1;
          w_next    = S_IDLE;
        end
      end
      S_WB: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    reject = start && busy;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_armed    <= 1'b0;
      r_cnt      <= 8'd0;
      err        <= 1'b0;
      r0         <= 8'd0;
      r1         <= 8'd0;
      mux_state  <= 2'd0;
      mux_value1 <= 8'd0;
      mux_value2 <= 8'd0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            mux_state  <= opcode;
            mux_value1 <= operand_a;
            mux_value2 <= operand_b;
            err        <= 1'b0;
          end
        end
        S_ISSUE: begin
          r_armed <= 1'b0;
          r_cnt   <= 8'd0;
        end
        S_WAIT: begin
          if (!mux_ready) r_armed <= 1'b1;
          r_cnt <= r_cnt + 8'd1;
          if (w_timeout) err <= 1'b1;
          // MUL returns high byte on out1 and low byte on out2.
          if (w_capture) begin
            if (mux_state == OP_MUL) begin
              r0 <= mux_out2;
              r1 <= mux_out1;
            end else begin
              r0 <= mux_out1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_r0_op_issuer.sv
// Randomised bench for r0_op_issuer: a transaction-level model predicts every
// cycle's outputs from the ready pattern handed to the multiplexer responder.
module tb_r0_op_issuer;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [1:0] opcode;
  logic [7:0] operand_a, operand_b;
  logic       mux_en;
  logic [1:0] mux_state;
  logic [7:0] mux_value1, mux_value2;
  logic       mux_ready;
  logic [7:0] mux_out1, mux_out2, r0, r1;
  logic       busy, done, reject, err;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  logic       e_busy, e_en, e_done, e_rej, e_err;
  logic [7:0] e_r0, e_r1, e_v1, e_v2;
  logic [1:0] e_st;

  logic       m_err;
  logic [7:0] m_r0, m_r1, m_v1, m_v2;
  logic [1:0] m_st;

  bit         rdy_pat [8];
  logic [7:0] o1_pat  [8];
  logic [7:0] o2_pat  [8];

  always #5 clk = ~clk;

  r0_op_issuer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode),
    .operand_a(operand_a), .operand_b(operand_b),
    .mux_en(mux_en), .mux_state(mux_state), .mux_value1(mux_value1), .mux_value2(mux_value2),
    .mux_ready(mux_ready), .mux_out1(mux_out1), .mux_out2(mux_out2),
    .r0(r0), .r1(r1), .busy(busy), .done(done), .reject(reject), .err(err)
  );

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",   {7'd0, busy},   {7'd0, e_busy});
      chk("mux_en", {7'd0, mux_en}, {7'd0, e_en});
      chk("done",   {7'd0, done},   {7'd0, e_done});
      chk("reject", {7'd0, reject}, {7'd0, e_rej});
      chk("err",    {7'd0, err},    {7'd0, e_err});
      chk("r0", r0, e_r0);
      chk("r1", r1, e_r1);
      chk("mux_state", {6'd0, mux_state}, {6'd0, e_st});
      chk("mux_value1", mux_value1, e_v1);
      chk("mux_value2", mux_value2, e_v2);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_err = 0; m_r0 = 0; m_r1 = 0; m_v1 = 0; m_v2 = 0; m_st = 0;
  endtask

  task automatic set_exp(input logic b, input logic en, input logic d, input logic rj);
    e_busy = b; e_en = en; e_done = d; e_rej = rj;
    e_err = m_err; e_r0 = m_r0; e_r1 = m_r1; e_st = m_st; e_v1 = m_v1; e_v2 = m_v2;
  endtask

  task automatic rnd_bus();
    mux_out1 = 8'($urandom); mux_out2 = 8'($urandom);
  endtask

  task automatic idle_cycle();
    cyc();
    start = 0; reset = 0; mux_ready = 1'($urandom_range(0, 1)); rnd_bus();
    set_exp(0, 0, 0, 0);
  endtask

  // One op; rdy_pat[k]/o*_pat[k] are what the multiplexer shows in the k-th WAIT cycle.
  task automatic run_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input bit stale, input int rej_at, input int rst_at);
    int  cap;
    int  nw;
    bit  seen0;
    cap = -1; seen0 = 0;
    for (int k = 0; k < TO; k++) begin
      if (rdy_pat[k] && seen0) begin cap = k; break; end
      if (!rdy_pat[k]) seen0 = 1;
    end
    nw = (cap >= 0) ? cap + 1 : TO;
    if (rst_at >= nw) rst_at = -1;
    if (rej_at >= nw || rej_at == rst_at) rej_at = -1;

    cyc();
    start = 1; reset = 0; opcode = op; operand_a = a; operand_b = b;
    mux_ready = stale ? 1'b1 : 1'($urandom_range(0, 1)); rnd_bus();
    set_exp(0, 0, 0, 0);

    cyc();
    start = 0; opcode = 2'($urandom); operand_a = 8'($urandom); operand_b = 8'($urandom);
    mux_ready = stale ? 1'b1 : 1'($urandom_range(0, 1)); rnd_bus();
    m_err = 0; m_st = op; m_v1 = a; m_v2 = b;
    set_exp(1, 1, 0, 0);

    for (int k = 0; k < nw; k++) begin
      cyc();
      mux_ready = rdy_pat[k]; mux_out1 = o1_pat[k]; mux_out2 = o2_pat[k];
      start = (k == rej_at); reset = (k == rst_at);
      opcode = 2'($urandom); operand_a = 8'($urandom); operand_b = 8'($urandom);
      set_exp(1, 1, 0, (k == rej_at));
      if (k == rst_at) begin
        cyc();
        reset = 0; start = 0; mux_ready = 1; rnd_bus();
        model_reset();
        set_exp(0, 0, 0, 0);
        for (int j = 0; j < 3; j++) begin
          cyc();
          mux_ready = 1; rnd_bus();
          set_exp(0, 0, 0, 0);
        end
        return;
      end
    end

    cyc();
    start = 0; reset = 0; mux_ready = 1'($urandom_range(0, 1)); rnd_bus();
    if (cap >= 0) begin
      if (op == 2'd2) begin
        m_r0 = o2_pat[cap]; m_r1 = o1_pat[cap];
      end else begin
        m_r0 = o1_pat[cap];
      end
      set_exp(1, 0, 1, 0);
    end else begin
      m_err = 1;
      set_exp(0, 0, 0, 0);
    end
  endtask

  task automatic fill_rand();
    for (int k = 0; k < 8; k++) begin
      rdy_pat[k] = 1'($urandom_range(0, 1));
      o1_pat[k] = 8'($urandom); o2_pat[k] = 8'($urandom);
    end
  endtask

  task automatic set_rdy(input bit p0, input bit p1, input bit p2, input bit p3);
    rdy_pat[0] = p0; rdy_pat[1] = p1; rdy_pat[2] = p2; rdy_pat[3] = p3;
  endtask

  initial begin
    reset = 1; start = 0; opcode = 0; operand_a = 0; operand_b = 0;
    mux_ready = 0; mux_out1 = 0; mux_out2 = 0;
    model_reset();
    set_exp(0, 0, 0, 0);
    cyc();
    cyc();
    chk_en = 1;
    chk("rst_r0", r0, 8'd0);
    chk("rst_r1", r1, 8'd0);
    chk("rst_mux_en", {7'd0, mux_en}, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_err", {7'd0, err}, 8'd0);
    chk("rst_mux_value1", mux_value1, 8'd0);
    idle_cycle();

    fill_rand(); set_rdy(0, 0, 1, 0); o1_pat[2] = 8'd42;
    run_op(2'd0, 8'd20, 8'd22, 0, -1, -1);
    chk("add_r0", r0, 8'd42);
    chk("add_r1", r1, 8'd0);
    chk("add_done", {7'd0, done}, 8'd1);
    chk("add_en_wb", {7'd0, mux_en}, 8'd0);

    fill_rand(); set_rdy(0, 1, 0, 0); o1_pat[1] = 8'h01; o2_pat[1] = 8'h2C;
    run_op(2'd2, 8'd100, 8'd3, 0, -1, -1);
    chk("mul_r0", r0, 8'h2C);
    chk("mul_r1", r1, 8'h01);

    fill_rand(); set_rdy(1, 0, 1, 0); o1_pat[0] = 8'd99; o1_pat[2] = 8'd7;
    run_op(2'd0, 8'd3, 8'd4, 1, -1, -1);
    chk("stale_r0", r0, 8'd7);

    fill_rand(); set_rdy(0, 0, 0, 0);
    run_op(2'd3, 8'd5, 8'd0, 0, -1, -1);
    chk("tmo_err", {7'd0, err}, 8'd1);
    chk("tmo_r0", r0, 8'd7);
    chk("tmo_r1", r1, 8'h01);
    chk("tmo_done", {7'd0, done}, 8'd0);

    fill_rand(); set_rdy(0, 1, 0, 0); o1_pat[1] = 8'h55;
    run_op(2'd1, 8'd9, 8'd1, 0, -1, -1);
    chk("errclr_err", {7'd0, err}, 8'd0);
    chk("errclr_r0", r0, 8'h55);

    fill_rand(); set_rdy(0, 0, 1, 0); o1_pat[2] = 8'h33;
    run_op(2'd0, 8'd1, 8'd2, 0, 1, -1);
    chk("rej_r0", r0, 8'h33);
    idle_cycle();
    chk("rej_no_second_op", {7'd0, busy}, 8'd0);

    fill_rand(); set_rdy(0, 0, 0, 1);
    run_op(2'd2, 8'd7, 8'd8, 0, -1, 1);
    chk("rstmid_r0", r0, 8'd0);
    chk("rstmid_r1", r1, 8'd0);
    chk("rstmid_en", {7'd0, mux_en}, 8'd0);
    chk("rstmid_done", {7'd0, done}, 8'd0);

    for (int i = 0; i < 200; i++) begin
      int rj, rs;
      fill_rand();
      rj = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TO - 1)) : -1;
      rs = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, TO - 1)) : -1;
      run_op(2'($urandom), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), rj, rs);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) idle_cycle();
    end

    idle_cycle();
    idle_cycle();
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
